// File: rtl/sys_defs.sv
// Shared core constants and the CDB broadcast packet used by RS, PRF, ROB.
// Data width comes from `XLEN (default 32).
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

   localparam int NUM_FU     = 6;
   localparam int CDB_WIDTH  = 3;
   localparam int PREG_IDX_W = 6;
   localparam int ROB_IDX_W  = 5;

   typedef struct packed {
      logic                  valid;
      logic [PREG_IDX_W-1:0] tag;
      logic [ROB_IDX_W-1:0]  rob_idx;
      logic [`XLEN-1:0]      value;
   } cdb_packet_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Rotating-priority multi-grant picker: up to W grants from N requests,
// scanning from start; lane k gets the k-th grant as a one-hot select.
module rr_multi_picker #(
   parameter int N  = 6,
   parameter int W  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [PW-1:0]  start,
   output logic [N-1:0]   grant,
   output logic [W*N-1:0] sel,
   output logic [W-1:0]   lane_valid,
   output logic           any,
   output logic [PW-1:0]  last
);

   always_comb begin
      int cnt;
      int idx;
      grant      = '0;
      sel        = '0;
      lane_valid = '0;
      last       = '0;
      cnt        = 0;
      idx        = 0;
      for (int o = 0; o < N; o++) begin
         idx = (int'(start) + o) % N;
         if (req[idx] && cnt < W) begin
            grant[idx]         = 1'b1;
            sel[cnt*N + idx]   = 1'b1;
            lane_valid[cnt]    = 1'b1;
            last               = PW'(idx);
            cnt                = cnt + 1;
         end
      end
   end

   assign any = |grant;

endmodule

// File: rtl/fu_cdb_arbiter.sv
// FU result holds arbitrated onto registered CDB lanes with rotating priority.
// Optional CDB_BYPASS_EN: empty-hold inputs may be granted in the same cycle.
`ifndef XLEN
`define XLEN 32
`endif

module fu_cdb_arbiter
   import sys_defs::*;
(
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            squash,
   input  logic [NUM_FU-1:0]               fu_valid,
   input  logic [NUM_FU*`XLEN-1:0]         fu_result,
   input  logic [NUM_FU*PREG_IDX_W-1:0]    fu_preg_tag,
   input  logic [NUM_FU*ROB_IDX_W-1:0]     fu_rob_idx,
   output logic [NUM_FU-1:0]               fu_ready,
   output logic [CDB_WIDTH-1:0]            cdb_valid,
   output logic [CDB_WIDTH*PREG_IDX_W-1:0] cdb_tag,
   output logic [CDB_WIDTH*`XLEN-1:0]      cdb_value,
   output logic [CDB_WIDTH*ROB_IDX_W-1:0]  cdb_rob_idx
);

   localparam int PW = $clog2(NUM_FU);

   cdb_packet_t hold   [NUM_FU];
   cdb_packet_t in_pkt [NUM_FU];
   cdb_packet_t src    [NUM_FU];
   cdb_packet_t lane   [CDB_WIDTH];
   cdb_packet_t cdb_q  [CDB_WIDTH];

   logic [NUM_FU-1:0]           hold_valid;
   logic [NUM_FU-1:0]           req;
   logic [NUM_FU-1:0]           grant;
   logic [NUM_FU-1:0]           byp;
   logic [NUM_FU-1:0]           accept;
   logic [CDB_WIDTH*NUM_FU-1:0] sel;
   logic [CDB_WIDTH-1:0]        lane_valid;
   logic                        any;
   logic [PW-1:0]               last;
   logic [PW-1:0]               rr_ptr;
   logic [PW-1:0]               nxt_ptr;

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         in_pkt[i].valid   = fu_valid[i];
         in_pkt[i].tag     = fu_preg_tag[i*PREG_IDX_W +: PREG_IDX_W];
         in_pkt[i].rob_idx = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
         in_pkt[i].value   = fu_result[i*`XLEN +: `XLEN];
      end
   end

`ifdef CDB_BYPASS_EN
   assign req = hold_valid | fu_valid;
   assign byp = grant & ~hold_valid;
   always_comb begin
      for (int i = 0; i < NUM_FU; i++)
         src[i] = hold_valid[i] ? hold[i] : in_pkt[i];
   end
`else
   assign req = hold_valid;
   assign byp = '0;
   always_comb begin
      for (int i = 0; i < NUM_FU; i++)
         src[i] = hold[i];
   end
`endif

   rr_multi_picker #(
      .N (NUM_FU),
      .W (CDB_WIDTH),
      .PW(PW)
   ) u_pick (
      .req       (req),
      .start     (rr_ptr),
      .grant     (grant),
      .sel       (sel),
      .lane_valid(lane_valid),
      .any       (any),
      .last      (last)
   );

   // Squash drains everything, so every FU may present (and lose) a result.
   assign fu_ready = {NUM_FU{squash}} | ~hold_valid | grant;
   assign accept   = fu_valid & fu_ready;
   assign nxt_ptr  = (last == PW'(NUM_FU - 1)) ? '0 : last + 1'b1;

   always_comb begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
         lane[k] = '0;
         for (int i = 0; i < NUM_FU; i++)
            if (sel[k*NUM_FU + i])
               lane[k] = lane[k] | src[i];
         lane[k].valid = lane_valid[k];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid <= '0;
         rr_ptr     <= '0;
         for (int i = 0; i < NUM_FU; i++)
            hold[i] <= '0;
         for (int k = 0; k < CDB_WIDTH; k++)
            cdb_q[k] <= '0;
      end else if (squash) begin
         hold_valid <= '0;
         for (int k = 0; k < CDB_WIDTH; k++)
            cdb_q[k].valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i] && !byp[i]) begin
               hold[i]       <= in_pkt[i];
               hold_valid[i] <= 1'b1;
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
         for (int k = 0; k < CDB_WIDTH; k++)
            cdb_q[k] <= lane[k];
         if (any)
            rr_ptr <= nxt_ptr;
      end
   end

   always_comb begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
         cdb_valid[k]                          = cdb_q[k].valid;
         cdb_tag[k*PREG_IDX_W +: PREG_IDX_W]   = cdb_q[k].tag;
         cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] = cdb_q[k].rob_idx;
         cdb_value[k*`XLEN +: `XLEN]           = cdb_q[k].value;
      end
   end

endmodule
